// File: rtl/heichips25_counter_pkg.sv
// ---------------------------------------------------------------------------
// heichips25_counter_pkg
// Shared types and constants for the HeiChips counter bank.
//   ctrl_t      : per-channel control register layout (en is bit 0)
//   cfg_addr_e  : register selector on the configuration port
//   CTRL_*      : bit positions inside the CTRL register
//   ch_width()  : width of a channel index, never less than one bit
// ---------------------------------------------------------------------------
package heichips25_counter_pkg;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_SAT    = 2;
    localparam int CTRL_RELOAD = 3;
    localparam int CTRL_IRQ_EN = 4;
    localparam int CTRL_W      = 5;

    // Shared prescaler: 8-bit divide value, selected by write-data bit 8
    localparam int PRE_W      = 8;
    localparam int PRE_WR_BIT = 8;

    typedef struct packed {
        logic irq_en;
        logic reload;
        logic sat;
        logic dir;
        logic en;
    } ctrl_t;

    typedef enum logic [1:0] {
        ADDR_CTRL   = 2'd0,
        ADDR_LOAD   = 2'd1,
        ADDR_CMP    = 2'd2,
        ADDR_STATUS = 2'd3
    } cfg_addr_e;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/heichips25_counter_channel.sv
// ---------------------------------------------------------------------------
// heichips25_counter_channel
// One event counter channel: count, LOAD, CMP, CTRL, edge history and the
// sticky match flag.
// Optional feature macro: HEICHIPS25_CNT_PRESCALE_EN (edge events are held
// until the next prescaler strobe).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   cnt_in       count event input for this channel
//   strobe       prescaler strobe; ticks only happen while it is high
//   wr_ctrl      write CTRL   (decoded by the top level)
//   wr_load      write LOAD and load the count
//   wr_cmp       write CMP
//   wr_status    STATUS write; wdata[0]=1 clears the match flag
//   wdata        write data
//   count        current count
//   match        sticky match flag
//   irq_req      match qualified by CTRL.irq_en
// ---------------------------------------------------------------------------
module heichips25_counter_channel
    import heichips25_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_in,
    input  logic             strobe,
    input  logic             wr_ctrl,
    input  logic             wr_load,
    input  logic             wr_cmp,
    input  logic             wr_status,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             irq_req
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] load;
    logic [WIDTH-1:0] cmp;
    ctrl_t            ctrl;
    logic             prev;
    logic             evt;
    logic             tick;
    logic             hit;
    logic             cfg_write;
    logic             clr;
    logic [WIDTH-1:0] count_next;
    logic [CTRL_W-1:0] ctrl_wdata;

    // CTRL only keeps its five defined bits; narrow counters zero-pad
    always_comb begin
        ctrl_wdata = '0;
        for (int b = 0; b < CTRL_W && b < WIDTH; b++) begin
            ctrl_wdata[b] = wdata[b];
        end
    end

`ifdef HEICHIPS25_CNT_PRESCALE_EN
    logic pend;

    // A rising edge seen between strobes is remembered until the strobe
    always_comb begin
        if (EDGE_MODE != 0) begin
            evt = (cnt_in & ~prev) | pend;
        end else begin
            evt = cnt_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (EDGE_MODE != 0) begin
            pend <= strobe ? 1'b0 : evt;
        end else begin
            pend <= 1'b0;
        end
    end
`else
    always_comb begin
        if (EDGE_MODE != 0) begin
            evt = cnt_in & ~prev;
        end else begin
            evt = cnt_in;
        end
    end
`endif

    // Next count in the selected direction, wrapping or saturating
    always_comb begin
        count_next = count;
        if (!ctrl.dir) begin
            if (count == MAX) begin
                count_next = ctrl.sat ? count : '0;
            end else begin
                count_next = count + 1'b1;
            end
        end else begin
            if (count == '0) begin
                count_next = ctrl.sat ? count : MAX;
            end else begin
                count_next = count - 1'b1;
            end
        end
    end

    // CTRL/LOAD/CMP writes win over a tick in the same cycle. A STATUS
    // write leaves the counter running, so a fresh match can beat the clear.
    assign cfg_write = wr_ctrl | wr_load | wr_cmp;
    assign tick      = ctrl.en & evt & strobe & ~cfg_write;
    assign hit       = tick & (count_next == cmp);
    assign clr       = wr_status & wdata[0];
    assign irq_req   = match & ctrl.irq_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            load  <= '0;
            cmp   <= '0;
            ctrl  <= '0;
            prev  <= 1'b0;
            match <= 1'b0;
        end else begin
            prev  <= cnt_in;
            match <= hit | (match & ~clr);
            if (wr_ctrl) begin
                ctrl <= ctrl_t'(ctrl_wdata);
            end else if (wr_load) begin
                load  <= wdata;
                count <= wdata;
            end else if (wr_cmp) begin
                cmp <= wdata;
            end else if (tick) begin
                count <= (hit && ctrl.reload) ? load : count_next;
            end
        end
    end

endmodule

// File: rtl/heichips25_counter_bank.sv
// ---------------------------------------------------------------------------
// heichips25_counter_bank
// Bank of NUM_CH independent WIDTH-bit event counters with a small
// synchronous configuration port and a registered readback mux.
// Optional feature macro: HEICHIPS25_CNT_PRESCALE_EN adds a shared 8-bit
// prescaler, written at STATUS with cfg_ch all-ones and cfg_wdata[8]=1.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   cnt_in       per-channel count events
//   cfg_we       config write strobe
//   cfg_ch       channel addressed by the write
//   cfg_addr     0 CTRL, 1 LOAD, 2 CMP, 3 STATUS (write-1-to-clear)
//   cfg_wdata    write data
//   rd_ch        channel selected for readback
//   rd_count     registered count of channel rd_ch (one cycle latency)
//   match        sticky per-channel match flags
//   irq          OR of (match & CTRL.irq_en) over all channels
// ---------------------------------------------------------------------------
module heichips25_counter_bank
    import heichips25_counter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 8,
    parameter int EDGE_MODE = 0,
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] cnt_in,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_addr,
    input  logic [WIDTH-1:0]  cfg_wdata,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [WIDTH-1:0]  rd_count,
    output logic [NUM_CH-1:0] match,
    output logic              irq
);

    cfg_addr_e        addr;
    logic             strobe;
    logic             pre_wr;
    logic [WIDTH-1:0] counts [NUM_CH];
    logic [NUM_CH-1:0] irq_vec;
    logic [WIDTH-1:0] rd_sel;

    assign addr = cfg_addr_e'(cfg_addr);

`ifdef HEICHIPS25_CNT_PRESCALE_EN
    logic [PRE_WR_BIT:0] pre_wdata;
    logic [PRE_W-1:0]    pre;
    logic [PRE_W-1:0]    pre_cnt;

    // Zero-extend narrow write data so the prescaler fields always exist
    always_comb begin
        pre_wdata = '0;
        for (int b = 0; b <= PRE_WR_BIT && b < WIDTH; b++) begin
            pre_wdata[b] = cfg_wdata[b];
        end
    end

    assign pre_wr = cfg_we && (addr == ADDR_STATUS) &&
                    (cfg_ch == {CH_W{1'b1}}) && pre_wdata[PRE_WR_BIT];
    assign strobe = (pre_cnt == pre);

    // Strobe every (PRE+1) cycles; a new PRE restarts the phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre     <= '0;
            pre_cnt <= '0;
        end else if (pre_wr) begin
            pre     <= pre_wdata[PRE_W-1:0];
            pre_cnt <= '0;
        end else begin
            pre_cnt <= strobe ? '0 : pre_cnt + 1'b1;
        end
    end
`else
    assign strobe = 1'b1;
    assign pre_wr = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = cfg_we && (cfg_ch == CH_W'(i));

        heichips25_counter_channel #(
            .WIDTH     (WIDTH),
            .EDGE_MODE (EDGE_MODE)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .cnt_in    (cnt_in[i]),
            .strobe    (strobe),
            .wr_ctrl   (sel && (addr == ADDR_CTRL)),
            .wr_load   (sel && (addr == ADDR_LOAD)),
            .wr_cmp    (sel && (addr == ADDR_CMP)),
            .wr_status (sel && (addr == ADDR_STATUS) && !pre_wr),
            .wdata     (cfg_wdata),
            .count     (counts[i]),
            .match     (match[i]),
            .irq_req   (irq_vec[i])
        );
    end

    assign irq = |irq_vec;

    // Out-of-range channel numbers read back as zero
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_sel = counts[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else begin
            rd_count <= rd_sel;
        end
    end

endmodule

// File: tb/tb_heichips25_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_heichips25_counter_bank
// Self-checking bench for heichips25_counter_bank (default build).
// A level-mode bank (u_dut_a) and an edge-mode bank (u_dut_b) share all
// inputs. A table of directed vectors covers the basic register behaviour;
// hand-written sequences cover wrap, saturation, reload, edge counting,
// write collisions and reset.
// ---------------------------------------------------------------------------
module tb_heichips25_counter_bank;
    import heichips25_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cnt_in;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [1:0] rd_ch;
    logic [7:0] rd_count_a, rd_count_b;
    logic [3:0] match_a, match_b;
    logic       irq_a, irq_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    heichips25_counter_bank #(.NUM_CH(4), .WIDTH(8), .EDGE_MODE(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .rd_ch(rd_ch), .rd_count(rd_count_a), .match(match_a), .irq(irq_a)
    );

    heichips25_counter_bank #(.NUM_CH(4), .WIDTH(8), .EDGE_MODE(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .rd_ch(rd_ch), .rd_count(rd_count_b), .match(match_b), .irq(irq_b)
    );

    typedef struct {
        logic [3:0] cnt;
        logic       we;
        logic [1:0] ch;
        cfg_addr_e  addr;
        logic [7:0] wdata;
        logic [1:0] rd;
        logic [7:0] e_rd;
        logic [3:0] e_match;
        logic       e_irq;
    } vec_t;

    vec_t vecs [23];

    // Wait for a rising edge, then move just past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        cnt_in    = v.cnt;
        cfg_we    = v.we;
        cfg_ch    = v.ch;
        cfg_addr  = v.addr;
        cfg_wdata = v.wdata;
        rd_ch     = v.rd;
        step();
    endtask

    task automatic cfg_write(input logic [1:0] ch, input cfg_addr_e a,
                             input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cnt_in    = '0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        rd_ch     = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] cnt, input logic we,
                                input logic [1:0] ch, input cfg_addr_e a,
                                input logic [7:0] wd, input logic [1:0] rd,
                                input logic [7:0] e_rd, input logic [3:0] e_m,
                                input logic e_irq);
        vec_t v;
        v.cnt = cnt; v.we = we; v.ch = ch; v.addr = a; v.wdata = wd;
        v.rd = rd; v.e_rd = e_rd; v.e_match = e_m; v.e_irq = e_irq;
        return v;
    endfunction

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   model;
        int   prev_model;
        logic mexp;
        logic [7:0] exp_rd3 [6];
        logic       exp_m3  [6];
        logic [7:0] exp_rd2 [5];
        logic       exp_i2  [5];

        // rd_count after a vector is the count before that vector's edge
        vecs[0]  = mk(4'h0, 1'b1, 2'd0, ADDR_LOAD,   8'h05, 2'd0, 8'h00, 4'h0, 1'b0);
        vecs[1]  = mk(4'h0, 1'b1, 2'd0, ADDR_CMP,    8'h07, 2'd0, 8'h05, 4'h0, 1'b0);
        vecs[2]  = mk(4'h0, 1'b1, 2'd0, ADDR_CTRL,   8'h11, 2'd0, 8'h05, 4'h0, 1'b0);
        vecs[3]  = mk(4'h1, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h05, 4'h0, 1'b0);
        vecs[4]  = mk(4'h1, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h06, 4'h1, 1'b1);
        vecs[5]  = mk(4'h0, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h07, 4'h1, 1'b1);
        vecs[6]  = mk(4'h0, 1'b1, 2'd0, ADDR_STATUS, 8'h01, 2'd0, 8'h07, 4'h0, 1'b0);
        vecs[7]  = mk(4'h0, 1'b1, 2'd0, ADDR_CTRL,   8'h01, 2'd0, 8'h07, 4'h0, 1'b0);
        vecs[8]  = mk(4'h1, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h07, 4'h0, 1'b0);
        vecs[9]  = mk(4'h1, 1'b1, 2'd0, ADDR_LOAD,   8'hFE, 2'd0, 8'h08, 4'h0, 1'b0);
        vecs[10] = mk(4'h1, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'hFE, 4'h0, 1'b0);
        vecs[11] = mk(4'h1, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'hFF, 4'h0, 1'b0);
        vecs[12] = mk(4'h0, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h00, 4'h0, 1'b0);
        vecs[13] = mk(4'h0, 1'b1, 2'd0, ADDR_CTRL,   8'h07, 2'd0, 8'h00, 4'h0, 1'b0);
        vecs[14] = mk(4'h0, 1'b1, 2'd0, ADDR_LOAD,   8'h03, 2'd0, 8'h00, 4'h0, 1'b0);
        vecs[15] = mk(4'h1, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h03, 4'h0, 1'b0);
        vecs[16] = mk(4'h1, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h02, 4'h0, 1'b0);
        vecs[17] = mk(4'h1, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h01, 4'h0, 1'b0);
        vecs[18] = mk(4'h1, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h00, 4'h0, 1'b0);
        vecs[19] = mk(4'h0, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h00, 4'h0, 1'b0);
        vecs[20] = mk(4'h0, 1'b1, 2'd1, ADDR_LOAD,   8'h33, 2'd1, 8'h00, 4'h0, 1'b0);
        vecs[21] = mk(4'h0, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd1, 8'h33, 4'h0, 1'b0);
        vecs[22] = mk(4'h0, 1'b0, 2'd0, ADDR_CTRL,   8'h00, 2'd0, 8'h00, 4'h0, 1'b0);

        // Reset state
        do_reset();
        check_output("reset rd_count_a", 32'(rd_count_a), 32'h0);
        check_output("reset match_a",    32'(match_a),    32'h0);
        check_output("reset irq_a",      32'(irq_a),      32'h0);
        check_output("reset rd_count_b", 32'(rd_count_b), 32'h0);

        // Directed table
        for (int i = 0; i < 23; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d rd_count", i), 32'(rd_count_a), 32'(vecs[i].e_rd));
            check_output($sformatf("vec%0d match", i),    32'(match_a),    32'(vecs[i].e_match));
            check_output($sformatf("vec%0d irq", i),      32'(irq_a),      32'(vecs[i].e_irq));
        end
        cfg_we = 1'b0;

        // Up wrap over 260 ticks with CMP=200
        do_reset();
        cfg_write(2'd0, ADDR_CMP, 8'd200);
        cfg_write(2'd0, ADDR_CTRL, 8'h01);
        rd_ch  = 2'd0;
        cnt_in = 4'h1;
        model  = 0;
        mexp   = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            step();
            prev_model = model;
            model = (model + 1) % 256;
            if (model == 200) mexp = 1'b1;
            check_output($sformatf("wrap%0d rd_count", k), 32'(rd_count_a), 32'(prev_model));
            check_output($sformatf("wrap%0d match", k),    32'(match_a[0]), 32'(mexp));
        end
        cnt_in = 4'h0;
        step();
        check_output("wrap final count", 32'(rd_count_a), 32'd4);

        // Down saturate with irq at CMP=0
        do_reset();
        cfg_write(2'd0, ADDR_LOAD, 8'd3);
        cfg_write(2'd0, ADDR_CTRL, 8'h17);
        exp_rd2 = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
        exp_i2  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        cnt_in = 4'h1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_output($sformatf("sat%0d rd_count", k), 32'(rd_count_a), 32'(exp_rd2[k]));
            check_output($sformatf("sat%0d irq", k),      32'(irq_a),      32'(exp_i2[k]));
        end
        cnt_in = 4'h0;

        // Auto-reload 10..12, STATUS clear mid-period keeps counting
        do_reset();
        cfg_write(2'd0, ADDR_LOAD, 8'd10);
        cfg_write(2'd0, ADDR_CMP,  8'd13);
        cfg_write(2'd0, ADDR_CTRL, 8'h09);
        exp_rd3 = '{8'd10, 8'd11, 8'd12, 8'd10, 8'd11, 8'd12};
        exp_m3  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cnt_in = 4'h1;
        for (int k = 0; k < 6; k++) begin
            cfg_we    = (k == 3);
            cfg_ch    = 2'd0;
            cfg_addr  = ADDR_STATUS;
            cfg_wdata = 8'h01;
            step();
            check_output($sformatf("reload%0d rd_count", k), 32'(rd_count_a), 32'(exp_rd3[k]));
            check_output($sformatf("reload%0d match", k),    32'(match_a[0]), 32'(exp_m3[k]));
        end
        cfg_we = 1'b0;
        cnt_in = 4'h0;
        step();
        check_output("reload wrapped to load", 32'(rd_count_a), 32'd10);

        // Edge mode: 5-cycle high then 3 pulses on channel 1
        do_reset();
        cfg_write(2'd1, ADDR_CTRL, 8'h01);
        rd_ch  = 2'd1;
        cnt_in = 4'h2;
        for (int k = 0; k < 5; k++) step();
        cnt_in = 4'h0;
        step();
        for (int k = 0; k < 3; k++) begin
            cnt_in = 4'h2;
            step();
            cnt_in = 4'h0;
            step();
        end
        step();
        check_output("edge count ch1",  32'(rd_count_b), 32'd4);
        check_output("level count ch1", 32'(rd_count_a), 32'd8);

        // LOAD write on channel 2 collides with a tick
        do_reset();
        cfg_write(2'd2, ADDR_CTRL, 8'h01);
        cnt_in    = 4'h4;
        cfg_we    = 1'b1;
        cfg_ch    = 2'd2;
        cfg_addr  = ADDR_LOAD;
        cfg_wdata = 8'h40;
        step();
        cfg_we = 1'b0;
        cnt_in = 4'h0;
        rd_ch  = 2'd2;
        step();
        check_output("collision load", 32'(rd_count_a), 32'h40);

        // STATUS clear loses against a new match in the same cycle
        cfg_write(2'd0, ADDR_LOAD, 8'd1);
        cfg_write(2'd0, ADDR_CMP,  8'd2);
        cfg_write(2'd0, ADDR_CTRL, 8'h19);
        cnt_in = 4'h1;
        step();
        check_output("clr pre match", 32'(match_a[0]), 32'd1);
        check_output("clr pre irq",   32'(irq_a),      32'd1);
        cfg_write(2'd0, ADDR_STATUS, 8'h01);
        check_output("set wins", 32'(match_a[0]), 32'd1);
        cnt_in = 4'h0;
        cfg_write(2'd0, ADDR_STATUS, 8'h01);
        check_output("plain clear", 32'(match_a[0]), 32'd0);
        cnt_in = 4'h1;
        step();
        check_output("rematch irq", 32'(irq_a), 32'd1);

        // Reset mid-count with a write pending
        rst_n     = 1'b0;
        cfg_we    = 1'b1;
        cfg_ch    = 2'd0;
        cfg_addr  = ADDR_LOAD;
        cfg_wdata = 8'h55;
        rd_ch     = 2'd0;
        step();
        check_output("rst match",    32'(match_a),    32'h0);
        check_output("rst irq",      32'(irq_a),      32'h0);
        check_output("rst rd_count", 32'(rd_count_a), 32'h0);
        rst_n  = 1'b1;
        cfg_we = 1'b0;
        step();
        check_output("rst write dropped", 32'(rd_count_a), 32'h0);
        check_output("rst match_b",       32'(match_b),    32'h0);
        check_output("rst irq_b",         32'(irq_b),      32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
